// File: rtl/alu_unit.sv
// Datapath ALU: combinational result for the 4-bit opcode plus a clocked
// status register holding zero/carry/divide-by-zero/illegal flags of the last result.
module alu_unit #(
   parameter int DATAWIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DATAWIDTH-1:0] a_i,
   input  logic [DATAWIDTH-1:0] b_i,
   input  logic [3:0]           opcode_i,
   output logic [DATAWIDTH-1:0] out_o,
   output logic                 zero_o,
   output logic                 carry_o,
   output logic                 dbz_o,
   output logic                 illegal_o
);

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_MUL = 4'd2;
   localparam logic [3:0] OP_DIV = 4'd3;
   localparam logic [3:0] OP_AND = 4'd4;
   localparam logic [3:0] OP_OR  = 4'd5;
   localparam logic [3:0] OP_XOR = 4'd6;
   localparam logic [3:0] OP_LW  = 4'd7;
   localparam logic [3:0] OP_SW  = 4'd8;
   localparam logic [3:0] OP_JMP = 4'd9;
   localparam logic [3:0] OP_BEQ = 4'd10;
   localparam logic [3:0] OP_BGT = 4'd11;
   localparam logic [3:0] OP_BLT = 4'd12;
   localparam logic [3:0] OP_LI  = 4'd13;

   localparam logic [DATAWIDTH-1:0] ALL_ONES  = {DATAWIDTH{1'b1}};
   localparam logic [DATAWIDTH-1:0] ALL_ZEROS = {DATAWIDTH{1'b0}};

   logic [DATAWIDTH:0]   sum_s;
   logic [DATAWIDTH:0]   diff_s;
   logic [DATAWIDTH-1:0] prod_s;
   logic [DATAWIDTH-1:0] quot_s;
   logic                 b_zero_s;
   logic                 carry_s;

   // Shared arithmetic terms; the extra top bit of sum/diff is carry/borrow.
   always_comb begin
      sum_s    = {1'b0, a_i} + {1'b0, b_i};
      diff_s   = {1'b0, a_i} - {1'b0, b_i};
      prod_s   = a_i * b_i;
      b_zero_s = (b_i == ALL_ZEROS);
      quot_s   = b_zero_s ? ALL_ONES : (a_i / b_i);
   end

   // Result select; address/immediate ops all reuse the adder.
   always_comb begin
      out_o   = ALL_ZEROS;
      carry_s = 1'b0;
      case (opcode_i)
         OP_ADD, OP_LW, OP_SW, OP_JMP, OP_BEQ, OP_BGT, OP_BLT, OP_LI: begin
            out_o   = sum_s[DATAWIDTH-1:0];
            carry_s = sum_s[DATAWIDTH];
         end
         OP_SUB: begin
            out_o   = diff_s[DATAWIDTH-1:0];
            carry_s = diff_s[DATAWIDTH];
         end
         OP_MUL:  out_o = prod_s;
         OP_DIV:  out_o = quot_s;
         OP_AND:  out_o = a_i & b_i;
         OP_OR:   out_o = a_i | b_i;
         OP_XOR:  out_o = a_i ^ b_i;
         default: begin
            out_o   = ALL_ZEROS;
            carry_s = 1'b0;
         end
      endcase
   end

   // Status register capturing the flags of the result present at the edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         zero_o    <= 1'b0;
         carry_o   <= 1'b0;
         dbz_o     <= 1'b0;
         illegal_o <= 1'b0;
      end else begin
         zero_o    <= (out_o == ALL_ZEROS);
         carry_o   <= carry_s;
         dbz_o     <= (opcode_i == OP_DIV) && b_zero_s;
         illegal_o <= (opcode_i > OP_LI);
      end
   end

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed literal cases plus randomized
// stimulus compared every cycle against an arithmetic reference model.
module tb_alu_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] a;
   logic [31:0] b;
   logic [3:0]  op;
   logic [31:0] out;
   logic        zero, carry, dbz, illegal;

   int n_cmp = 0;
   int n_err = 0;

   logic exp_zero, exp_carry, exp_dbz, exp_illegal;
   logic flags_valid = 1'b0;

   alu_unit #(.DATAWIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .a_i(a), .b_i(b), .opcode_i(op),
      .out_o(out), .zero_o(zero), .carry_o(carry), .dbz_o(dbz), .illegal_o(illegal)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] model_out(input logic [31:0] x, input logic [31:0] y,
                                             input logic [3:0] o);
      longint unsigned ux, uy, r;
      ux = 64'(x);
      uy = 64'(y);
      case (o)
         4'd0, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13: r = ux + uy;
         4'd1: r = ux + 64'h1_0000_0000 - uy;
         4'd2: r = ux * uy;
         4'd3: r = (uy == 64'd0) ? 64'hFFFF_FFFF : ux / uy;
         4'd4: r = ux & uy;
         4'd5: r = ux | uy;
         4'd6: r = ux ^ uy;
         default: r = 64'd0;
      endcase
      return r[31:0];
   endfunction

   function automatic logic model_carry(input logic [31:0] x, input logic [31:0] y,
                                        input logic [3:0] o);
      if (o == 4'd0 || (o >= 4'd7 && o <= 4'd13))
         return (64'(x) + 64'(y)) >= 64'h1_0000_0000;
      else if (o == 4'd1)
         return x < y;
      else
         return 1'b0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (a=%h b=%h op=%0d rst_n=%b) t=%0t",
                  name, act, exp, a, b, op, rst_n, $time);
      end
   endtask

   // Reference status register: flags of the inputs seen at each posedge.
   always @(posedge clk) begin
      exp_zero    <= rst_n ? (model_out(a, b, op) == 32'd0) : 1'b0;
      exp_carry   <= rst_n ? model_carry(a, b, op) : 1'b0;
      exp_dbz     <= rst_n ? (op == 4'd3 && b == 32'd0) : 1'b0;
      exp_illegal <= rst_n ? (op >= 4'd14) : 1'b0;
      flags_valid <= 1'b1;
   end

   // Continuous compare on the falling edge.
   always @(negedge clk) begin
      chk("model_out", out, model_out(a, b, op));
      if (flags_valid) begin
         chk("model_zero",    {31'd0, zero},    {31'd0, exp_zero});
         chk("model_carry",   {31'd0, carry},   {31'd0, exp_carry});
         chk("model_dbz",     {31'd0, dbz},     {31'd0, exp_dbz});
         chk("model_illegal", {31'd0, illegal}, {31'd0, exp_illegal});
      end
   end

   task automatic step(input logic [31:0] x, input logic [31:0] y, input logic [3:0] o);
      @(posedge clk);
      #2;
      a  = x;
      b  = y;
      op = o;
   endtask

   task automatic after_edge();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] sweep_exp [14];

   initial begin
      rst_n = 1'b0;
      a     = 32'd0;
      b     = 32'd0;
      op    = 4'd0;
      sweep_exp = '{32'd69, 32'hFFFF_FFFF, 32'd1190, 32'd0, 32'd34, 32'd35, 32'd1,
                    32'd69, 32'd69, 32'd69, 32'd69, 32'd69, 32'd69, 32'd69};

      after_edge();
      chk("reset_zero",    {31'd0, zero},    32'd0);
      chk("reset_carry",   {31'd0, carry},   32'd0);
      chk("reset_dbz",     {31'd0, dbz},     32'd0);
      chk("reset_illegal", {31'd0, illegal}, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 14; i++) begin
         step(32'd34, 32'd35, 4'(i));
         @(negedge clk);
         chk($sformatf("sweep_out_op%0d", i), out, sweep_exp[i]);
         after_edge();
         chk($sformatf("sweep_carry_op%0d", i), {31'd0, carry}, (i == 1) ? 32'd1 : 32'd0);
      end

      step(32'd100, 32'd0, 4'd3);
      @(negedge clk);
      chk("div0_out", out, 32'hFFFF_FFFF);
      after_edge();
      chk("div0_dbz", {31'd0, dbz}, 32'd1);
      step(32'd100, 32'd7, 4'd3);
      @(negedge clk);
      chk("div7_out", out, 32'd14);
      after_edge();
      chk("div7_dbz", {31'd0, dbz}, 32'd0);

      step(32'hFFFF_FFFF, 32'd1, 4'd0);
      @(negedge clk);
      chk("addwrap_out", out, 32'd0);
      after_edge();
      chk("addwrap_zero",  {31'd0, zero},  32'd1);
      chk("addwrap_carry", {31'd0, carry}, 32'd1);

      step(32'd5, 32'd6, 4'd15);
      @(negedge clk);
      chk("illegal_out", out, 32'd0);
      after_edge();
      chk("illegal_flag", {31'd0, illegal}, 32'd1);
      chk("illegal_zero", {31'd0, zero},    32'd1);

      step(32'd1, 32'd2, 4'd1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_sub_out", out, 32'hFFFF_FFFF);
      after_edge();
      chk("rst_zero",    {31'd0, zero},    32'd0);
      chk("rst_carry",   {31'd0, carry},   32'd0);
      chk("rst_dbz",     {31'd0, dbz},     32'd0);
      chk("rst_illegal", {31'd0, illegal}, 32'd0);
      rst_n = 1'b1;
      after_edge();
      chk("rst_release_carry", {31'd0, carry}, 32'd1);

      step(32'h0001_0000, 32'h0001_0000, 4'd2);
      @(negedge clk);
      chk("mul_trunc_out", out, 32'd0);
      after_edge();
      chk("mul_trunc_zero", {31'd0, zero}, 32'd1);

      for (int n = 0; n < 3000; n++) begin
         logic [31:0] ra, rb;
         ra = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3))
                                          : 32'($urandom);
         case ($urandom_range(0, 5))
            0:       rb = 32'd0;
            1:       rb = 32'($urandom_range(1, 255));
            2:       rb = ra;
            default: rb = 32'($urandom);
         endcase
         step(ra, rb, 4'($urandom_range(0, 15)));
         rst_n = ($urandom_range(0, 19) != 0);
      end
      rst_n = 1'b1;
      after_edge();
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
